axi_arb: RTL and testbench

//  Shares the core's single AXI4 master port between IFU (requester 0) and LSU (requester 1).

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_arb_if.sv | 66 ++++++
 rtl/axi_arb_rr_arb2.sv | 19 +
 rtl/axi_arb.sv | 123 ++++++++++++
 tb/tb_axi_arb.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Shared encodings for the IFU/LSU AXI arbiter: FSM states, fixed AXI field values
// and requester indices.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_AR   = 3'd1,
    ARB_R    = 3'd2,
    ARB_AW_W = 3'd3,
    ARB_B    = 3'd4,
    ARB_RSP  = 3'd5
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int ARB_IFU = 0;
  localparam int ARB_LSU = 1;

endpackage

// File: rtl/axi_arb_if.sv
// Bundles for the arbiter: the two-requester request/response side and the
// single AXI4 master side (master = arbiter, slave = memory/interconnect).
interface arb_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_wen;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [7:0]          req_wstrb;
  logic [5:0]          req_size;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awready, awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wready, wvalid, wlast;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              bready, bvalid;
  logic [1:0]        bresp;
  logic [3:0]        bid;
  logic              arready, arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rready, rvalid, rlast;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        rid;

  modport master (
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
           bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
  modport slave (
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
           bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/axi_arb_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    idx = 1'b0;
    gnt = 2'b00;
    if (req == 2'b11) idx = ~last;
    else if (req[ARB_LSU]) idx = 1'b1;
    if (req != 2'b00) gnt = idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_arb.sv
// Shares one AXI4 master port between IFU and LSU; one single-beat transaction
// at a time, response routed back to the requester that was granted.
module axi_arb
  import axi_arb_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic clk_i,
  input  logic rst_i,
  arb_req_if.slave req,
  axi4_if.master   axi
);

  arb_state_e        state, state_nxt;
  logic              last, sel, gnt_idx;
  logic [1:0]        gnt;
  logic              lat_wen;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_wstrb;
  logic [2:0]        lat_size;
  logic              aw_done, w_done;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              req_hs, aw_hs, w_hs;

  rr_arb2 u_rr (
    .req  (req.req_valid),
    .last (last),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign req_hs = (state == ARB_IDLE) && (gnt != 2'b00);
  assign aw_hs  = axi.awvalid && axi.awready;
  assign w_hs   = axi.wvalid && axi.wready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (req_hs) state_nxt = req.req_wen[gnt_idx] ? ARB_AW_W : ARB_AR;
      ARB_AR:   if (axi.arready) state_nxt = ARB_R;
      ARB_R:    if (axi.rvalid) state_nxt = ARB_RSP;
      ARB_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ARB_B;
      ARB_B:    if (axi.bvalid) state_nxt = ARB_RSP;
      ARB_RSP:  if (req.rsp_ready[sel]) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Reset also clears the payload latch so an aborted transaction leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      lat_size  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        sel       <= gnt_idx;
        last      <= gnt_idx;
        lat_wen   <= req.req_wen[gnt_idx];
        lat_addr  <= gnt_idx ? req.req_addr[2*ADDR_W-1:ADDR_W]  : req.req_addr[ADDR_W-1:0];
        lat_wdata <= gnt_idx ? req.req_wdata[2*DATA_W-1:DATA_W] : req.req_wdata[DATA_W-1:0];
        lat_wstrb <= gnt_idx ? req.req_wstrb[7:4] : req.req_wstrb[3:0];
        lat_size  <= gnt_idx ? req.req_size[5:3]  : req.req_size[2:0];
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == ARB_R && axi.rvalid) begin
        rdata_q <= axi.rdata;
        err_q   <= (axi.rresp != AXI_RESP_OKAY) || (axi.rid != AXI_ID) || !axi.rlast;
      end
      if (state == ARB_B && axi.bvalid) begin
        rdata_q <= '0;
        err_q   <= (axi.bresp != AXI_RESP_OKAY) || (axi.bid != AXI_ID);
      end
    end
  end

  assign req.req_ready = (state == ARB_IDLE) ? gnt : 2'b00;
  assign req.rsp_valid = (state == ARB_RSP) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_err   = err_q;

  // Valids decode registered state/done flags only, so they never depend on slave inputs.
  assign axi.arvalid = (state == ARB_AR);
  assign axi.rready  = (state == ARB_R);
  assign axi.awvalid = (state == ARB_AW_W) && !aw_done;
  assign axi.wvalid  = (state == ARB_AW_W) && !w_done;
  assign axi.bready  = (state == ARB_B);

  assign axi.araddr  = lat_addr;
  assign axi.arsize  = lat_size;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.awaddr  = lat_addr;
  assign axi.awsize  = lat_size;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = lat_wdata;
  assign axi.wstrb   = lat_wstrb;
  assign axi.wlast   = 1'b1;

  logic unused_ok;
  assign unused_ok = lat_wen;

endmodule

// File: tb/tb_axi_arb.sv
// Directed bench for axi_arb: behavioural AXI slave with programmable ready delays
// and response fields, hand-computed expectations per cycle.
module tb_axi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_req_if #(.ADDR_W(32), .DATA_W(32)) rbus ();
  axi4_if    #(.ADDR_W(32), .DATA_W(32)) mbus ();

  axi_arb #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd0)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .req   (rbus),
    .axi   (mbus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  logic [3:0]  s_rid = 4'd0, s_bid = 4'd0;
  logic        s_rlast = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    rbus.req_valid[i]       = 1'b1;
    rbus.req_wen[i]         = wen;
    rbus.req_addr[i*32 +: 32]  = addr;
    rbus.req_wdata[i*32 +: 32] = wdata;
    rbus.req_wstrb[i*4 +: 4]   = strb;
    rbus.req_size[i*3 +: 3]    = 3'd2;
  endtask

  task automatic wait_ready(input logic [1:0] want, input string tag);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      if (rbus.req_ready != 2'b00) got = 1;
    end
    chk(tag, rbus.req_ready, want);
  endtask

  task automatic wait_rsp(input int i, input string tag);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      if (rbus.rsp_valid[i]) got = 1;
    end
    chk(tag, rbus.rsp_valid, (i == 1) ? 2'b10 : 2'b01);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Behavioural slave: readies after programmable waits, R/B answer as soon as ready is seen.
  initial begin
    int aw_cnt, w_cnt, ar_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    mbus.awready = 0; mbus.wready = 0; mbus.arready = 0;
    mbus.rvalid = 0; mbus.rdata = '0; mbus.rresp = 0; mbus.rid = 0; mbus.rlast = 0;
    mbus.bvalid = 0; mbus.bresp = 0; mbus.bid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        mbus.awready = 0; mbus.wready = 0; mbus.arready = 0;
        mbus.rvalid = 0; mbus.bvalid = 0;
      end else begin
        if (mbus.awvalid) begin mbus.awready = (aw_cnt == aw_wait); aw_cnt++; end
        else begin mbus.awready = 0; aw_cnt = 0; end
        if (mbus.wvalid) begin mbus.wready = (w_cnt == w_wait); w_cnt++; end
        else begin mbus.wready = 0; w_cnt = 0; end
        if (mbus.arvalid) begin mbus.arready = (ar_cnt == ar_wait); ar_cnt++; end
        else begin mbus.arready = 0; ar_cnt = 0; end
        mbus.rvalid = mbus.rready;
        mbus.rdata  = s_rdata;
        mbus.rresp  = s_rresp;
        mbus.rid    = s_rid;
        mbus.rlast  = s_rlast;
        mbus.bvalid = mbus.bready;
        mbus.bresp  = s_bresp;
        mbus.bid    = s_bid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rbus.req_valid = '0; rbus.req_wen = '0; rbus.req_addr = '0; rbus.req_wdata = '0;
    rbus.req_wstrb = '0; rbus.req_size = '0; rbus.rsp_ready = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_req_ready", rbus.req_ready, 2'b00);
    chk("rst_rsp_valid", rbus.rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rbus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   rbus.rsp_err, 1'b0);
    chk("rst_arvalid",   mbus.arvalid, 1'b0);
    chk("rst_awvalid",   mbus.awvalid, 1'b0);
    chk("rst_wvalid",    mbus.wvalid, 1'b0);
    chk("rst_rready",    mbus.rready, 1'b0);
    chk("rst_bready",    mbus.bready, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: IFU read, zero-wait slave
    s_rdata = 32'h0000_0413;
    rbus.rsp_ready = 2'b01;
    drive_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    #1;
    chk("t1_req_ready", rbus.req_ready, 2'b01);
    tick();
    rbus.req_valid = 2'b00;
    chk("t1_c1_arvalid", mbus.arvalid, 1'b1);
    chk("t1_c1_araddr",  mbus.araddr, 32'h8000_0000);
    chk("t1_c1_arsize",  mbus.arsize, 3'd2);
    chk("t1_c1_arlen",   mbus.arlen, 8'd0);
    chk("t1_c1_arburst", mbus.arburst, 2'b01);
    chk("t1_c1_arid",    mbus.arid, 4'd0);
    tick();
    chk("t1_c2_arvalid", mbus.arvalid, 1'b0);
    chk("t1_c2_rready",  mbus.rready, 1'b1);
    tick();
    chk("t1_c3_rsp_valid", rbus.rsp_valid, 2'b01);
    chk("t1_c3_rdata",     rbus.rsp_rdata, 32'h0000_0413);
    chk("t1_c3_err",       rbus.rsp_err, 1'b0);
    tick();
    chk("t1_c4_rsp_valid", rbus.rsp_valid, 2'b00);
    drive_req(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
    #1;
    chk("t1_c4_reaccept", rbus.req_ready, 2'b01);
    rbus.req_valid = 2'b00;
    rbus.rsp_ready = 2'b00;
    tick();

    // 2: simultaneous requests alternate IFU, LSU, IFU
    do_reset();
    s_rdata = 32'h0000_0011;
    rbus.rsp_ready = 2'b11;
    drive_req(0, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h9000_0000, 32'h0, 4'h0);
    #1;
    chk("t2_first_ifu", rbus.req_ready, 2'b01);
    tick();
    rbus.req_valid[0] = 1'b0;
    wait_ready(2'b10, "t2_second_lsu");
    drive_req(0, 1'b0, 32'h8000_000C, 32'h0, 4'h0);
    #1;
    chk("t2_second_tie", rbus.req_ready, 2'b10);
    wait_ready(2'b01, "t2_third_ifu");
    rbus.req_valid = 2'b00;
    rbus.rsp_ready = 2'b00;
    tick();

    // 3: LSU write, awready delayed 3 cycles, wready immediate
    aw_wait = 3; w_wait = 0;
    rbus.rsp_ready = 2'b10;
    drive_req(1, 1'b1, 32'hA000_0000, 32'hDEAD_BEEF, 4'b0011);
    #1;
    chk("t3_req_ready", rbus.req_ready, 2'b10);
    tick();
    rbus.req_valid = 2'b00;
    chk("t3_c1_awvalid", mbus.awvalid, 1'b1);
    chk("t3_c1_wvalid",  mbus.wvalid, 1'b1);
    chk("t3_c1_awaddr",  mbus.awaddr, 32'hA000_0000);
    chk("t3_c1_wdata",   mbus.wdata, 32'hDEAD_BEEF);
    chk("t3_c1_wstrb",   mbus.wstrb, 4'b0011);
    chk("t3_c1_wlast",   mbus.wlast, 1'b1);
    chk("t3_c1_awburst", mbus.awburst, 2'b01);
    tick();
    chk("t3_c2_wvalid",  mbus.wvalid, 1'b0);
    chk("t3_c2_awvalid", mbus.awvalid, 1'b1);
    tick();
    chk("t3_c3_awvalid", mbus.awvalid, 1'b1);
    tick();
    chk("t3_c4_awvalid", mbus.awvalid, 1'b1);
    tick();
    chk("t3_c5_awvalid", mbus.awvalid, 1'b0);
    chk("t3_c5_bready",  mbus.bready, 1'b1);
    tick();
    chk("t3_c6_rsp_valid", rbus.rsp_valid, 2'b10);
    chk("t3_c6_err",       rbus.rsp_err, 1'b0);
    chk("t3_c6_rdata",     rbus.rsp_rdata, 32'h0);
    tick();
    rbus.rsp_ready = 2'b00;
    aw_wait = 0;

    // 4/5: error responses, rsp_ready held low with a competing request
    s_rdata = 32'h1234_5678;
    s_rresp = 2'b10;
    drive_req(0, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    #1;
    chk("t4_req_ready", rbus.req_ready, 2'b01);
    tick();
    rbus.req_valid = 2'b00;
    drive_req(1, 1'b0, 32'h8000_0200, 32'h0, 4'h0);
    wait_rsp(0, "t4_rsp_valid");
    chk("t4_err_rresp", rbus.rsp_err, 1'b1);
    chk("t4_rdata",     rbus.rsp_rdata, 32'h1234_5678);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_hold_valid", rbus.rsp_valid, 2'b01);
      chk("t5_hold_rdata", rbus.rsp_rdata, 32'h1234_5678);
      chk("t5_hold_err",   rbus.rsp_err, 1'b1);
      chk("t5_no_ready",   rbus.req_ready, 2'b00);
    end
    rbus.rsp_ready = 2'b01;
    tick();
    chk("t5_released", rbus.rsp_valid, 2'b00);
    chk("t5_lsu_next", rbus.req_ready, 2'b10);
    rbus.rsp_ready = 2'b10;
    s_rresp = 2'b00;
    s_rid   = 4'd5;
    s_rdata = 32'h0000_CAFE;
    tick();
    rbus.req_valid = 2'b00;
    wait_rsp(1, "t4b_rsp_valid");
    chk("t4b_err_rid", rbus.rsp_err, 1'b1);
    chk("t4b_rdata",   rbus.rsp_rdata, 32'h0000_CAFE);
    tick();
    s_rid   = 4'd0;
    s_rlast = 1'b0;
    rbus.rsp_ready = 2'b01;
    drive_req(0, 1'b0, 32'h8000_0300, 32'h0, 4'h0);
    tick();
    rbus.req_valid = 2'b00;
    wait_rsp(0, "t4c_rsp_valid");
    chk("t4c_err_rlast", rbus.rsp_err, 1'b1);
    tick();
    s_rlast = 1'b1;
    rbus.rsp_ready = 2'b00;

    // 6: reset while in AW_W, then a fresh IFU read
    aw_wait = 3; w_wait = 5;
    drive_req(1, 1'b1, 32'hA000_0010, 32'h0000_0055, 4'hF);
    tick();
    rbus.req_valid = 2'b00;
    chk("t6_pre_awvalid", mbus.awvalid, 1'b1);
    chk("t6_pre_wvalid",  mbus.wvalid, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_awvalid",   mbus.awvalid, 1'b0);
    chk("t6_rst_wvalid",    mbus.wvalid, 1'b0);
    chk("t6_rst_bready",    mbus.bready, 1'b0);
    chk("t6_rst_rsp_valid", rbus.rsp_valid, 2'b00);
    chk("t6_rst_rdata",     rbus.rsp_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    aw_wait = 0; w_wait = 0;
    tick();
    s_rdata = 32'h0000_6789;
    rbus.rsp_ready = 2'b01;
    drive_req(0, 1'b0, 32'h8000_0400, 32'h0, 4'h0);
    #1;
    chk("t6_req_ready", rbus.req_ready, 2'b01);
    tick();
    rbus.req_valid = 2'b00;
    chk("t6_c1_arvalid", mbus.arvalid, 1'b1);
    chk("t6_c1_araddr",  mbus.araddr, 32'h8000_0400);
    tick();
    tick();
    chk("t6_c3_rsp_valid", rbus.rsp_valid, 2'b01);
    chk("t6_c3_rdata",     rbus.rsp_rdata, 32'h0000_6789);
    chk("t6_c3_err",       rbus.rsp_err, 1'b0);
    tick();
    chk("t6_c4_rsp_valid", rbus.rsp_valid, 2'b00);
    rbus.rsp_ready = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
